// File: rtl/instr_fsm_ctrl.sv
// instr_fsm_ctrl
// Latches one 16-bit instruction, decodes it and sequences the register-file/ALU
// datapath through a Moore state machine. The outputs depend only on the state and
// the latched IR.
//
// Handshake: w acts as "ready" and s acts as "valid". An instruction transfers on a
// rising clk edge where the state is S_WAIT (w = 1) and s = 1. s has no effect in
// any other state. IR then holds in_instr until the FSM returns to S_WAIT.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   s, in_instr         start strobe and the instruction to latch
//   w, bad              idle/ready flag; unsupported-opcode flag (S_DECODE only)
//   loada..loads        datapath register load enables
//   asel, bsel, vsel    operand selects and one-hot writeback mux select
//   ALUop, shift        ALU operation and shifter control (IR[4:3])
//   write, readnum,
//   writenum            register-file write enable and register numbers
//   sximm8, sximm5      sign-extended immediates from IR
//   o_state             current FSM state, exposed for debug
module instr_fsm_ctrl #(
    parameter int IW     = 16,
    parameter int IMM8_W = 8,
    parameter int IMM5_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [IW-1:0] in_instr,
    output logic          w,
    output logic          bad,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [3:0]    vsel,
    output logic [1:0]    ALUop,
    output logic [1:0]    shift,
    output logic          write,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic [IW-1:0] sximm8,
    output logic [IW-1:0] sximm5,
    output logic [2:0]    o_state
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WIMM   = 3'd2,
        S_GETA   = 3'd3,
        S_GETB   = 3'd4,
        S_ALU    = 3'd5,
        S_WREG   = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_ir;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [2:0] w_rm;
    logic [2:0] w_nsel;
    logic       w_mov_imm;
    logic       w_mov_reg;
    logic       w_is_alu;
    logic       w_is_cmp;
    logic       w_is_mvn;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_rm     = r_ir[2:0];

    assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_alu  = (w_opcode == 3'b101);
    assign w_is_cmp  = w_is_alu && (w_op == 2'b01);
    assign w_is_mvn  = w_is_alu && (w_op == 2'b11);

    // Pure functions of IR, so they are valid in every state.
    assign sximm8   = {{(IW-IMM8_W){r_ir[IMM8_W-1]}}, r_ir[IMM8_W-1:0]};
    assign sximm5   = {{(IW-IMM5_W){r_ir[IMM5_W-1]}}, r_ir[IMM5_W-1:0]};
    assign shift    = r_ir[4:3];
    // The register file has a single port-number mux that feeds both fields.
    assign readnum  = w_nsel;
    assign writenum = w_nsel;
    assign o_state  = r_state;

    // Reset has priority over start, so a held s cannot load IR while in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_WAIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT && s) begin
                r_ir <= in_instr;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w      = 1'b0;
        bad    = 1'b0;
        loada  = 1'b0;
        loadb  = 1'b0;
        loadc  = 1'b0;
        loads  = 1'b0;
        asel   = 1'b0;
        bsel   = 1'b0;
        vsel   = 4'b0001;
        ALUop  = 2'b00;
        write  = 1'b0;
        w_nsel = w_rn;

        case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_mov_imm)                   w_next = S_WIMM;
                else if (w_mov_reg || w_is_mvn)  w_next = S_GETB;
                else if (w_is_alu)               w_next = S_GETA;
                else begin
                    bad    = 1'b1;
                    w_next = S_WAIT;
                end
            end
            S_WIMM: begin
                w_nsel = w_rn;
                vsel   = 4'b0010;
                write  = 1'b1;
                w_next = S_WAIT;
            end
            S_GETA: begin
                w_nsel = w_rn;
                loada  = 1'b1;
                w_next = S_GETB;
            end
            S_GETB: begin
                w_nsel = w_rm;
                loadb  = 1'b1;
                w_next = S_ALU;
            end
            S_ALU: begin
                // MOV reg passes B through an add with A forced to zero.
                if (w_mov_reg) begin
                    ALUop = 2'b00;
                    asel  = 1'b1;
                end else begin
                    ALUop = w_op;
                end
                if (w_is_cmp) begin
                    loads  = 1'b1;
                    w_next = S_WAIT;
                end else begin
                    loadc  = 1'b1;
                    w_next = S_WREG;
                end
            end
            S_WREG: begin
                w_nsel = w_rd;
                vsel   = 4'b0001;
                write  = 1'b1;
                w_next = S_WAIT;
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

endmodule
